// File: rtl/arb_pkg.sv
// Shared definitions for the 4-source round-robin select arbiter.
//   N_SRC        : number of request sources feeding the downstream mux
//   SEL_W        : width of the binary mux select
//   arb_state_t  : arbiter FSM states (IDLE, GRANT)
//   sel_to_onehot: converts a binary select into the matching one-hot grant
package arb_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_SRC-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        sel_to_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker.
// Returns the first set bit of req when scanning upward from ptr, wrapping 3->0.
// Ports:
//   req   [3:0] in  : request vector
//   ptr   [1:0] in  : highest-priority position for this pick
//   idx   [1:0] out : index of the chosen request (ptr when none is set)
//   found       out : at least one request is set
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [2*N_SRC-1:0] dbl_s;
    logic [N_SRC-1:0]   rot_s;
    logic [SEL_W-1:0]   off_s;

    // Doubling the vector lets a plain part-select perform the rotation:
    // rot_s[j] is req[(ptr + j) mod 4], so bit 0 is the top-priority source.
    assign dbl_s = {req, req};
    assign rot_s = dbl_s[{1'b0, ptr} +: N_SRC];

    // Fixed-priority encode of the rotated vector gives the offset from ptr.
    always_comb begin
        off_s = 2'd0;
        found = 1'b1;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s = 2'd0;
                found = 1'b0;
            end
        endcase
    end

    // Offset back into absolute source numbering; 2-bit add wraps naturally.
    assign idx = ptr + off_s;

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin arbiter producing the registered select for a downstream
// 4-to-1 mux. A source keeps the grant for up to BURST_LEN accepted transfers,
// or until it drops its request in a transfer cycle; the grant then rotates
// with the releasing source at lowest priority and no idle bubble.
// Ports:
//   clk        in        : rising-edge clock
//   rst        in        : synchronous active-high reset
//   req  [3:0] in        : per-source requests (bit i = mux input i)
//   out_ready  in        : consumer accepts the current word
//   sel  [1:0] out (reg) : binary index of the granted source
//   grant[3:0] out (reg) : one-hot of sel while out_valid, else 0
//   out_valid  out (reg) : selected mux word is valid
module rr_sel_arbiter4
    import arb_pkg::*;
#(
    parameter int BURST_LEN = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_SRC-1:0] grant,
    output logic             out_valid
);

    localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t       state_r, state_n_s;
    logic [SEL_W-1:0] ptr_r, ptr_n_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_n_s;
    logic [SEL_W-1:0] sel_r, sel_n_s;
    logic [N_SRC-1:0] grant_r, grant_n_s;
    logic             valid_r, valid_n_s;

    logic [SEL_W-1:0] pick_ptr_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             pick_found_s;
    logic             transfer_s;
    logic             release_s;

    // While granting, the only arbitration point is a release, and then the
    // priority must start just past the releasing source; in IDLE use ptr.
    always_comb begin
        if (state_r == GRANT) begin
            pick_ptr_s = sel_r + 2'd1;
        end else begin
            pick_ptr_s = ptr_r;
        end
    end

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    assign transfer_s = valid_r & out_ready;
    assign release_s  = transfer_s & ((beat_cnt_r == LAST_BEAT) | ~req[sel_r]);

    // Next-state and next-output logic; everything holds unless updated.
    always_comb begin
        state_n_s    = state_r;
        ptr_n_s      = ptr_r;
        beat_cnt_n_s = beat_cnt_r;
        sel_n_s      = sel_r;
        grant_n_s    = grant_r;
        valid_n_s    = valid_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_n_s    = GRANT;
                    sel_n_s      = pick_idx_s;
                    grant_n_s    = sel_to_onehot(pick_idx_s);
                    valid_n_s    = 1'b1;
                    beat_cnt_n_s = {CNT_W{1'b0}};
                end else begin
                    state_n_s = IDLE;
                    grant_n_s = {N_SRC{1'b0}};
                    valid_n_s = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    ptr_n_s      = sel_r + 2'd1;
                    beat_cnt_n_s = {CNT_W{1'b0}};
                    if (pick_found_s) begin
                        // Back-to-back grant: out_valid stays high.
                        state_n_s = GRANT;
                        sel_n_s   = pick_idx_s;
                        grant_n_s = sel_to_onehot(pick_idx_s);
                        valid_n_s = 1'b1;
                    end else begin
                        state_n_s = IDLE;
                        grant_n_s = {N_SRC{1'b0}};
                        valid_n_s = 1'b0;
                    end
                end else if (transfer_s) begin
                    // Cannot pass LAST_BEAT: reaching it forces a release.
                    beat_cnt_n_s = beat_cnt_r + CNT_W'(1);
                end else begin
                    // Stalled: no retraction, select and valid hold.
                    state_n_s = GRANT;
                end
            end
            default: begin
                state_n_s = IDLE;
                grant_n_s = {N_SRC{1'b0}};
                valid_n_s = 1'b0;
            end
        endcase
    end

    // State, pointer, beat counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= {SEL_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
            sel_r      <= {SEL_W{1'b0}};
            grant_r    <= {N_SRC{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            ptr_r      <= ptr_n_s;
            beat_cnt_r <= beat_cnt_n_s;
            sel_r      <= sel_n_s;
            grant_r    <= grant_n_s;
            valid_r    <= valid_n_s;
        end
    end

    assign sel       = sel_r;
    assign grant     = grant_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Self-checking bench for rr_sel_arbiter4: one instance with BURST_LEN=1 (a)
// and one with BURST_LEN=4 (b), each tracked by a transfer-counting model.
module tb_rr_sel_arbiter4;

    logic       clk;
    logic       rst_a, rst_b;
    logic [3:0] req_a, req_b;
    logic       rdy_a, rdy_b;
    logic [1:0] sel_a, sel_b;
    logic [3:0] grant_a, grant_b;
    logic       valid_a, valid_b;

    int tests_run = 0;
    int fails     = 0;

    // Reference model state, index 0 = instance a, 1 = instance b.
    int m_burst [2] = '{1, 4};
    bit m_valid [2];
    int m_sel   [2];
    int m_ptr   [2];
    int m_beats [2];

    rr_sel_arbiter4 #(.BURST_LEN(1)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .out_ready(rdy_a),
        .sel(sel_a), .grant(grant_a), .out_valid(valid_a)
    );

    rr_sel_arbiter4 #(.BURST_LEN(4)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .out_ready(rdy_b),
        .sel(sel_b), .grant(grant_b), .out_valid(valid_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant(input int u);
        logic [3:0] one;
        one = 4'b0001;
        return m_valid[u] ? (one << m_sel[u]) : 4'b0000;
    endfunction

    // One clock edge of the behavioural model for instance u.
    task automatic model_step(input int u, input logic [3:0] r, input logic rdy, input logic rs);
        int p;
        if (rs) begin
            m_valid[u] = 1'b0; m_sel[u] = 0; m_ptr[u] = 0; m_beats[u] = 0;
        end else if (!m_valid[u]) begin
            p = pick(r, m_ptr[u]);
            if (p >= 0) begin
                m_sel[u] = p; m_valid[u] = 1'b1; m_beats[u] = 0;
            end
        end else if (rdy) begin
            m_beats[u] = m_beats[u] + 1;
            if (m_beats[u] == m_burst[u] || !r[m_sel[u]]) begin
                m_ptr[u] = (m_sel[u] + 1) % 4;
                p = pick(r, m_ptr[u]);
                if (p >= 0) begin
                    m_sel[u] = p; m_beats[u] = 0;
                end else begin
                    m_valid[u] = 1'b0;
                end
            end
        end
    endtask

    task automatic clk_step();
        model_step(0, req_a, rdy_a, rst_a);
        model_step(1, req_b, rdy_b, rst_b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; req_a = 4'b1111; req_b = 4'b1111;
        rdy_a = 1'b0; rdy_b = 1'b0;
        for (int c = 0; c < 2; c++) begin
            clk_step();
            tests_run++;
            if (sel_a !== 2'd0 || grant_a !== 4'b0000 || valid_a !== 1'b0) begin
                fails++;
                $display("FAIL reset_a: sel=%0d grant=%b valid=%b, expected 0/0000/0", sel_a, grant_a, valid_a);
            end
            tests_run++;
            if (sel_b !== 2'd0 || grant_b !== 4'b0000 || valid_b !== 1'b0) begin
                fails++;
                $display("FAIL reset_b: sel=%0d grant=%b valid=%b, expected 0/0000/0", sel_b, grant_b, valid_b);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        clk_step();
        tests_run++;
        if (sel_a !== 2'd0 || grant_a !== 4'b0001 || valid_a !== 1'b1) begin
            fails++;
            $display("FAIL first_grant_a: sel=%0d grant=%b valid=%b, expected 0/0001/1", sel_a, grant_a, valid_a);
        end
        tests_run++;
        if (sel_b !== 2'd0 || grant_b !== 4'b0001 || valid_b !== 1'b1) begin
            fails++;
            $display("FAIL first_grant_b: sel=%0d grant=%b valid=%b, expected 0/0001/1", sel_b, grant_b, valid_b);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] one;
        int         e;
        one = 4'b0001;
        req_a = 4'b1111; rdy_a = 1'b1;
        for (int c = 0; c < 12; c++) begin
            clk_step();
            e = (c + 1) % 4;
            tests_run++;
            if (sel_a !== 2'(e) || valid_a !== 1'b1 || grant_a !== (one << e)) begin
                fails++;
                $display("FAIL fairness[%0d]: sel=%0d grant=%b valid=%b, expected sel=%0d valid=1", c, sel_a, grant_a, valid_a, e);
            end
        end
    endtask

    task automatic test_stall();
        rst_a = 1'b1; clk_step(); rst_a = 1'b0;
        req_a = 4'b0100; rdy_a = 1'b0;
        clk_step();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req_a = 4'b0000;
            clk_step();
            tests_run++;
            if (sel_a !== 2'd2 || valid_a !== 1'b1 || grant_a !== 4'b0100) begin
                fails++;
                $display("FAIL stall_hold[%0d]: sel=%0d grant=%b valid=%b, expected 2/0100/1", c, sel_a, grant_a, valid_a);
            end
        end
        rdy_a = 1'b1;
        clk_step();
        tests_run++;
        if (valid_a !== 1'b0 || grant_a !== 4'b0000) begin
            fails++;
            $display("FAIL stall_release: grant=%b valid=%b, expected 0000/0", grant_a, valid_a);
        end
    endtask

    task automatic test_burst();
        int e;
        rst_b = 1'b1; clk_step(); rst_b = 1'b0;
        req_b = 4'b1010; rdy_b = 1'b1;
        clk_step();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) clk_step();
            e = ((c / 4) % 2 == 1) ? 3 : 1;
            tests_run++;
            if (sel_b !== 2'(e) || valid_b !== 1'b1) begin
                fails++;
                $display("FAIL burst[%0d]: sel=%0d valid=%b, expected sel=%0d valid=1", c, sel_b, valid_b, e);
            end
        end
    endtask

    task automatic test_early_release();
        rst_b = 1'b1; clk_step(); rst_b = 1'b0;
        req_b = 4'b0100; rdy_b = 1'b0;
        clk_step();
        req_b = 4'b1001; rdy_b = 1'b1;
        clk_step();
        tests_run++;
        if (sel_b !== 2'd3 || valid_b !== 1'b1 || dut_b.ptr_r !== 2'd3) begin
            fails++;
            $display("FAIL wrap_grant: sel=%0d valid=%b ptr=%0d, expected sel=3 valid=1 ptr=3", sel_b, valid_b, dut_b.ptr_r);
        end
        clk_step();
        tests_run++;
        if (sel_b !== 2'd3 || valid_b !== 1'b1) begin
            fails++;
            $display("FAIL early_beat1: sel=%0d valid=%b, expected 3/1", sel_b, valid_b);
        end
        req_b = 4'b0001;
        clk_step();
        tests_run++;
        if (sel_b !== 2'd0 || valid_b !== 1'b1 || grant_b !== 4'b0001) begin
            fails++;
            $display("FAIL early_release: sel=%0d grant=%b valid=%b, expected 0/0001/1", sel_b, grant_b, valid_b);
        end
    endtask

    task automatic test_mid_reset();
        rst_b = 1'b1; clk_step(); rst_b = 1'b0;
        req_b = 4'b0010; rdy_b = 1'b0;
        clk_step();
        req_b = 4'b0100; rdy_b = 1'b1;
        clk_step();
        clk_step();
        tests_run++;
        if (sel_b !== 2'd2 || valid_b !== 1'b1 || dut_b.ptr_r !== 2'd2) begin
            fails++;
            $display("FAIL pre_reset: sel=%0d valid=%b ptr=%0d, expected 2/1/2", sel_b, valid_b, dut_b.ptr_r);
        end
        rst_b = 1'b1;
        clk_step();
        tests_run++;
        if (sel_b !== 2'd0 || grant_b !== 4'b0000 || valid_b !== 1'b0 || dut_b.ptr_r !== 2'd0) begin
            fails++;
            $display("FAIL mid_reset: sel=%0d grant=%b valid=%b ptr=%0d, expected all 0", sel_b, grant_b, valid_b, dut_b.ptr_r);
        end
        rst_b = 1'b0; req_b = 4'b1111; rdy_b = 1'b0;
        clk_step();
        tests_run++;
        if (sel_b !== 2'd0 || grant_b !== 4'b0001 || valid_b !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_grant: sel=%0d grant=%b valid=%b, expected 0/0001/1", sel_b, grant_b, valid_b);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            req_a = 4'($urandom); rdy_a = ($urandom_range(0, 3) != 0); rst_a = ($urandom_range(0, 63) == 0);
            req_b = 4'($urandom); rdy_b = ($urandom_range(0, 3) != 0); rst_b = ($urandom_range(0, 63) == 0);
            clk_step();
            tests_run++;
            if (sel_a !== 2'(m_sel[0]) || valid_a !== m_valid[0] || grant_a !== exp_grant(0)) begin
                fails++;
                $display("FAIL random_a[%0d]: sel=%0d grant=%b valid=%b, expected sel=%0d grant=%b valid=%b",
                         c, sel_a, grant_a, valid_a, m_sel[0], exp_grant(0), m_valid[0]);
            end
            tests_run++;
            if (sel_b !== 2'(m_sel[1]) || valid_b !== m_valid[1] || grant_b !== exp_grant(1)) begin
                fails++;
                $display("FAIL random_b[%0d]: sel=%0d grant=%b valid=%b, expected sel=%0d grant=%b valid=%b",
                         c, sel_b, grant_b, valid_b, m_sel[1], exp_grant(1), m_valid[1]);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = 4'b0000; req_b = 4'b0000;
        rdy_a = 1'b0; rdy_b = 1'b0;
        test_reset();
        test_fairness();
        test_stall();
        test_burst();
        test_early_release();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
